inst_fetch_axi: RTL and testbench

INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

---
 rtl/mips_axi_pkg.sv | 47 ++++
 rtl/inst_fetch_axi.sv | 181 ++++++++++++++++++
 tb/tb_inst_fetch_axi.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_axi_pkg.sv
// Purpose: shared definitions for the MIPS core AXI instruction-fetch path.
//   Holds the fetch FSM state encoding, the fixed AR-channel attribute values
//   for a two-word instruction burst, the output payload struct and a
//   small alignment helper.
`timescale 1ns/1ps
package mips_axi_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned STATE_W = 3;

  // Fetch FSM state encoding
  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_AR    = 3'd1;
  localparam logic [STATE_W-1:0] S_R0    = 3'd2;
  localparam logic [STATE_W-1:0] S_R1    = 3'd3;
  localparam logic [STATE_W-1:0] S_HOLD  = 3'd4;
  localparam logic [STATE_W-1:0] S_DRAIN = 3'd5;

  // AR-channel attributes for an instruction-pair fetch
  localparam logic [3:0] ARID_IFETCH   = 4'd0;
  localparam logic [3:0] ARLEN_2BEAT   = 4'b0001;
  localparam logic [2:0] ARSIZE_WORD   = 3'b010;
  localparam logic [1:0] ARBURST_INCR  = 2'b01;
  localparam logic [1:0] ARLOCK_NORMAL = 2'b00;
  localparam logic [3:0] ARCACHE_NONE  = 4'b0000;
  localparam logic [2:0] ARPROT_NONE   = 3'b000;

  // Error bit positions in out_err
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RRESP    = 1;

  // Instruction-pair payload handed to IF_1/IF_2
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst_1;
    logic [DATA_W-1:0] inst_2;
    logic [ERR_W-1:0]  err;
  } fetch_pair_t;

  // Instruction addresses must be word aligned
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_axi.sv
// Purpose: fetches an instruction pair (pc, pc+4) as one 2-beat AXI INCR
//   read burst and holds it for the IF pair until consumed or flushed.
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   fetch_req, fetch_pc   request for the pair starting at fetch_pc
//   flush                 redirect: discard the current fetch
//   out_ready             IF pair consumes the held output
//   out_valid/out_pc/out_inst_1/out_inst_2/out_err   registered result
//   stall                 combinational: fetch pending (IF delay_soft)
//   ar*/r*                AXI read address / read data channels
`timescale 1ns/1ps
module inst_fetch_axi
  import mips_axi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst_1,
  output logic [DATA_W-1:0] out_inst_2,
  output logic [ERR_W-1:0]  out_err,
  output logic              stall,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              rready
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               r_flush_pend;
  logic               r_arvalid;
  logic               r_rready;
  logic               r_out_valid;
  logic [ADDR_W-1:0]  r_araddr;
  fetch_pair_t        r_pair;
  logic               w_accept;
  logic               w_misaligned;
  logic               w_beat_err;
  logic               w_stall;

  assign w_accept     = fetch_req && !flush;
  assign w_misaligned = is_misaligned(fetch_pc);
  assign w_beat_err   = (rresp != 2'b00);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_misaligned ? S_HOLD : S_AR;
      end
      S_AR: begin
        // A flush cannot retract arvalid; the burst is drained instead.
        if (arready) w_next = (flush || r_flush_pend) ? S_DRAIN : S_R0;
      end
      S_R0: begin
        if (flush) begin
          w_next = (rvalid && rlast) ? S_IDLE : S_DRAIN;
        end else if (rvalid) begin
          w_next = rlast ? S_HOLD : S_R1;
        end
      end
      S_R1: begin
        if (flush) begin
          w_next = (rvalid && rlast) ? S_IDLE : S_DRAIN;
        end else if (rvalid) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || out_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (rvalid && rlast) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stall: fetch outstanding, or a request being presented in IDLE
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:                  w_stall = fetch_req;
      S_AR, S_R0, S_R1, S_DRAIN: w_stall = 1'b1;
      default:                 w_stall = 1'b0;
    endcase
  end

  // State and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_arvalid   <= (w_next == S_AR);
      r_rready    <= (w_next == S_R0) || (w_next == S_R1) || (w_next == S_DRAIN);
      r_out_valid <= (w_next == S_HOLD);
      if (r_state == S_AR) begin
        if (flush) r_flush_pend <= 1'b1;
      end else begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  // Address and instruction-pair payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr <= '0;
      r_pair   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pair.pc     <= fetch_pc;
            r_pair.inst_1 <= '0;
            r_pair.inst_2 <= '0;
            r_pair.err    <= {1'b0, w_misaligned};
            if (!w_misaligned) r_araddr <= fetch_pc;
          end
        end
        S_R0: begin
          if (rvalid && !flush) begin
            r_pair.inst_1 <= rdata;
            // An early rlast means the pair is incomplete: flag it as a bus error.
            r_pair.err[ERR_RRESP] <= r_pair.err[ERR_RRESP] | w_beat_err | rlast;
            if (rlast) r_pair.inst_2 <= '0;
          end
        end
        S_R1: begin
          if (rvalid && !flush) begin
            r_pair.inst_2         <= rdata;
            r_pair.err[ERR_RRESP] <= r_pair.err[ERR_RRESP] | w_beat_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pc     = r_pair.pc;
  assign out_inst_1 = r_pair.inst_1;
  assign out_inst_2 = r_pair.inst_2;
  assign out_err    = r_pair.err;
  assign stall      = w_stall;

  assign arvalid = r_arvalid;
  assign araddr  = r_araddr;
  assign rready  = r_rready;

  assign arid    = ARID_IFETCH;
  assign arlen   = ARLEN_2BEAT;
  assign arsize  = ARSIZE_WORD;
  assign arburst = ARBURST_INCR;
  assign arlock  = ARLOCK_NORMAL;
  assign arcache = ARCACHE_NONE;
  assign arprot  = ARPROT_NONE;

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Purpose: directed self-checking bench for inst_fetch_axi. A cycle table
//   covers the basic pair fetch, a misaligned fetch and a stalled-consumer
//   fetch with an error response; hand sequences cover arready back-pressure,
//   flush in AR/R1/HOLD, early rlast and reset mid-burst.
`timescale 1ns/1ps
module tb_inst_fetch_axi;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic        rst;
    logic        freq;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        arrdy;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rl;
  } in_t;

  typedef struct packed {
    logic        arv;
    logic [31:0] araddr;
    logic        rrdy;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [1:0]  err;
    logic        stall;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst_1;
  logic [31:0] out_inst_2;
  logic [1:0]  out_err;
  logic        stall;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rready;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  inst_fetch_axi dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst_1(out_inst_1), .out_inst_2(out_inst_2), .out_err(out_err),
    .stall(stall), .arvalid(arvalid), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arready(arready), .rvalid(rvalid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(input logic r, input logic f, input logic [31:0] pc,
                             input logic fl, input logic od, input logic ar,
                             input logic rv, input logic [31:0] rd,
                             input logic [1:0] rr, input logic rl);
    mi = '{rst:r, freq:f, pc:pc, fl:fl, ordy:od, arrdy:ar, rv:rv, rd:rd, rr:rr, rl:rl};
  endfunction

  function automatic out_t mo(input logic arv, input logic [31:0] aa, input logic rr,
                              input logic ov, input logic [31:0] opc,
                              input logic [31:0] i1, input logic [31:0] i2,
                              input logic [1:0] err, input logic st);
    mo = '{arv:arv, araddr:aa, rrdy:rr, ov:ov, opc:opc, i1:i1, i2:i2, err:err, stall:st};
  endfunction

  function automatic in_t idle_in();
    return mi(L, L, 32'h0, L, L, L, L, 32'h0, 2'b00, L);
  endfunction

  function automatic out_t cur();
    return mo(arvalid, araddr, rready, out_valid, out_pc, out_inst_1, out_inst_2,
              out_err, stall);
  endfunction

  // Drive one cycle's inputs after the falling edge; outputs settle 1ns later.
  task automatic tick(input in_t v);
    @(negedge clk);
    reset     = v.rst;
    fetch_req = v.freq;
    fetch_pc  = v.pc;
    flush     = v.fl;
    out_ready = v.ordy;
    arready   = v.arrdy;
    rvalid    = v.rv;
    rdata     = v.rd;
    rresp     = v.rr;
    rlast     = v.rl;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Fixed AR attributes as one packed word
  task automatic chk_const(input string nm);
    logic [31:0] act;
    act = {10'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot};
    chk(nm, act, {10'd0, 4'h0, 4'h1, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic pair fetch at reset vector
    tbl.push_back('{idle_in(), mo(L, 32'h0, L, L, 32'h0, 32'h0, 32'h0, 2'b00, L)});
    tbl.push_back('{mi(L, H, 32'hBFC00000, L, L, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'h0, L, L, 32'h0, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L),
                    mo(H, 32'hBFC00000, L, L, 32'hBFC00000, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, L, H, 32'h3C080001, 2'b00, L),
                    mo(L, 32'hBFC00000, H, L, 32'hBFC00000, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, L, H, 32'h25080004, 2'b00, H),
                    mo(L, 32'hBFC00000, H, L, 32'hBFC00000, 32'h3C080001, 32'h0, 2'b00, H)});
    tbl.push_back('{idle_in(),
                    mo(L, 32'hBFC00000, L, H, 32'hBFC00000, 32'h3C080001, 32'h25080004, 2'b00, L)});
    tbl.push_back('{mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'hBFC00000, L, H, 32'hBFC00000, 32'h3C080001, 32'h25080004, 2'b00, L)});
    tbl.push_back('{idle_in(),
                    mo(L, 32'hBFC00000, L, L, 32'hBFC00000, 32'h3C080001, 32'h25080004, 2'b00, L)});
    // Misaligned fetch: no AR, error pair next cycle
    tbl.push_back('{mi(L, H, 32'hBFC00002, L, L, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'hBFC00000, L, L, 32'hBFC00000, 32'h3C080001, 32'h25080004, 2'b00, H)});
    tbl.push_back('{idle_in(), mo(L, 32'hBFC00000, L, H, 32'hBFC00002, 32'h0, 32'h0, 2'b01, L)});
    tbl.push_back('{mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'hBFC00000, L, H, 32'hBFC00002, 32'h0, 32'h0, 2'b01, L)});
    tbl.push_back('{idle_in(), mo(L, 32'hBFC00000, L, L, 32'hBFC00002, 32'h0, 32'h0, 2'b01, L)});
    // Slow AR, error on beat 2, consumer stalls 3 cycles
    tbl.push_back('{mi(L, H, 32'hBFC00008, L, L, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'hBFC00000, L, L, 32'hBFC00002, 32'h0, 32'h0, 2'b01, H)});
    tbl.push_back('{idle_in(), mo(H, 32'hBFC00008, L, L, 32'hBFC00008, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L),
                    mo(H, 32'hBFC00008, L, L, 32'hBFC00008, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, L, H, 32'h11111111, 2'b00, L),
                    mo(L, 32'hBFC00008, H, L, 32'hBFC00008, 32'h0, 32'h0, 2'b00, H)});
    tbl.push_back('{mi(L, L, 32'h0, L, L, L, H, 32'h22222222, 2'b10, H),
                    mo(L, 32'hBFC00008, H, L, 32'hBFC00008, 32'h11111111, 32'h0, 2'b00, H)});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{idle_in(),
                      mo(L, 32'hBFC00008, L, H, 32'hBFC00008, 32'h11111111, 32'h22222222, 2'b10, L)});
    tbl.push_back('{mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L),
                    mo(L, 32'hBFC00008, L, H, 32'hBFC00008, 32'h11111111, 32'h22222222, 2'b10, L)});
    tbl.push_back('{idle_in(),
                    mo(L, 32'hBFC00008, L, L, 32'hBFC00008, 32'h11111111, 32'h22222222, 2'b10, L)});

    tick(mi(H, L, 32'h0, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(H, L, 32'h0, L, L, L, L, 32'h0, 2'b00, L));
    chk_const("const_in_reset");

    foreach (tbl[k]) begin
      tick(tbl[k].i);
      chkv($sformatf("row%0d", k), cur(), tbl[k].o);
    end
    chk_const("const_after_table");

    // arready held low 5 cycles: request stable, one handshake
    tick(mi(L, H, 32'hBFC00020, L, L, L, L, 32'h0, 2'b00, L));
    for (int k = 0; k < 5; k++) begin
      tick(idle_in());
      chk($sformatf("bp_arvalid%0d", k), 32'(arvalid), 32'd1);
      chk($sformatf("bp_araddr%0d", k), araddr, 32'hBFC00020);
    end
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    chk("bp_arvalid_hs", 32'(arvalid), 32'd1);
    tick(mi(L, L, 32'h0, L, L, H, H, 32'hA0A0A0A0, 2'b00, L));
    chk("bp_single_hs", 32'(arvalid), 32'd0);
    chk("bp_rready", 32'(rready), 32'd1);
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hB0B0B0B0, 2'b00, H));
    tick(mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L));
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_inst1", out_inst_1, 32'hA0A0A0A0);
    chk("bp_inst2", out_inst_2, 32'hB0B0B0B0);
    tick(idle_in());
    chk("bp_release", 32'(out_valid), 32'd0);

    // Flush in R1: drain second beat, then a fresh fetch
    tick(mi(L, H, 32'hBFC00040, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hC1C1C1C1, 2'b00, L));
    tick(mi(L, L, 32'h0, H, L, L, L, 32'h0, 2'b00, L));
    chk("fr1_rready", 32'(rready), 32'd1);
    tick(idle_in());
    chk("drain_rready", 32'(rready), 32'd1);
    chk("drain_stall", 32'(stall), 32'd1);
    chk("drain_valid", 32'(out_valid), 32'd0);
    tick(mi(L, L, 32'h0, H, L, L, H, 32'hC2C2C2C2, 2'b00, H));
    chk("drain_valid_beat", 32'(out_valid), 32'd0);
    tick(idle_in());
    chk("drain_done_valid", 32'(out_valid), 32'd0);
    chk("drain_done_stall", 32'(stall), 32'd0);
    chk("drain_done_rready", 32'(rready), 32'd0);
    tick(mi(L, H, 32'hBFC00010, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    chk("refetch_araddr", araddr, 32'hBFC00010);
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hD1D1D1D1, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hD2D2D2D2, 2'b00, H));
    tick(mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L));
    chkv("refetch_pair", cur(),
         mo(L, 32'hBFC00010, L, H, 32'hBFC00010, 32'hD1D1D1D1, 32'hD2D2D2D2, 2'b00, L));
    tick(idle_in());

    // fetch_req together with flush in IDLE starts nothing
    tick(mi(L, H, 32'hBFC00100, H, L, L, L, 32'h0, 2'b00, L));
    chk("reqflush_stall", 32'(stall), 32'd1);
    tick(idle_in());
    chk("reqflush_arvalid", 32'(arvalid), 32'd0);
    chk("reqflush_idle", 32'(stall), 32'd0);

    // Flush in AR: arvalid holds until handshake, then drain
    tick(mi(L, H, 32'hBFC00200, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, H, L, L, L, 32'h0, 2'b00, L));
    chk("far_arvalid0", 32'(arvalid), 32'd1);
    tick(idle_in());
    chk("far_arvalid1", 32'(arvalid), 32'd1);
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hE0E0E0E0, 2'b00, L));
    chk("far_drain_rready", 32'(rready), 32'd1);
    chk("far_drain_arvalid", 32'(arvalid), 32'd0);
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hE1E1E1E1, 2'b00, H));
    chk("far_drain_valid", 32'(out_valid), 32'd0);
    tick(idle_in());
    chk("far_done_stall", 32'(stall), 32'd0);
    chk("far_done_valid", 32'(out_valid), 32'd0);

    // Flush and out_ready together in HOLD: flush wins
    tick(mi(L, H, 32'hBFC00300, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hF1F1F1F1, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'hF2F2F2F2, 2'b00, H));
    tick(idle_in());
    chk("hf_valid", 32'(out_valid), 32'd1);
    tick(mi(L, L, 32'h0, H, H, L, L, 32'h0, 2'b00, L));
    tick(idle_in());
    chk("hf_discard", 32'(out_valid), 32'd0);
    chk("hf_idle_stall", 32'(stall), 32'd0);

    // rlast on first beat: error flagged, inst_2 zero
    tick(mi(L, H, 32'hBFC00600, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'h77777777, 2'b00, H));
    tick(idle_in());
    chkv("early_rlast", cur(),
         mo(L, 32'hBFC00600, L, H, 32'hBFC00600, 32'h77777777, 32'h0, 2'b10, L));
    tick(mi(L, L, 32'h0, L, H, L, L, 32'h0, 2'b00, L));

    // Reset while in R1 abandons the burst
    tick(mi(L, H, 32'hBFC00400, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, L, H, 32'h12345678, 2'b01, L));
    tick(mi(H, L, 32'h0, L, L, L, L, 32'h0, 2'b00, L));
    chk("r1_before_reset", 32'(rready), 32'd1);
    tick(idle_in());
    chkv("reset_r1", cur(), mo(L, 32'h0, L, L, 32'h0, 32'h0, 32'h0, 2'b00, L));
    chk_const("const_after_reset");
    tick(mi(L, H, 32'hBFC00500, L, L, L, L, 32'h0, 2'b00, L));
    tick(mi(L, L, 32'h0, L, L, H, L, 32'h0, 2'b00, L));
    chk("post_reset_fetch", araddr, 32'hBFC00500);
    chk("post_reset_arvalid", 32'(arvalid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
